guess_sequencer: RTL and testbench
==================================

GUESS_SEQUENCER -- requirements
Module: guess_sequencer

Interface
REQ-001 SHALL have parameter FLAG_LEN, default 32, number of bytes per guess attempt (range 1..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port clear  input  1  synchronous restart of an attempt.
REQ-005 SHALL have port in_valid  input  1  upstream byte present.
REQ-006 SHALL have port in_data  input  8  upstream guess byte.
REQ-007 SHALL have port in_ready  output  1  block accepts a byte this cycle.
REQ-008 SHALL have port byte_num  output  5  index driven to the byte checker.
REQ-009 SHALL have port byte_guess  output  8  byte driven to the byte checker.
REQ-010 SHALL have port guess_valid  input  1  combinational checker verdict for byte_num/byte_guess.
REQ-011 SHALL have port match_count  output  6  number of matching bytes in the current attempt.
REQ-012 SHALL have port done  output  1  attempt complete.
REQ-013 SHALL have port pass  output  1  all FLAG_LEN bytes matched; meaningful only while done=1.

Function
REQ-014 SHALL use states IDLE, CHECK and DONE.
REQ-015 SHALL assert in_ready only in IDLE, or in CHECK while idx < FLAG_LEN, and never while clear=1.
REQ-016 SHALL accept a byte on a rising edge where in_valid=1 and in_ready=1.
REQ-017 SHALL, on acceptance, register byte_guess<=in_data, byte_num<=idx and pend<=1, then increment idx; the first acceptance moves IDLE->CHECK.
REQ-018 SHALL, on the edge after an acceptance (pend=1), sample guess_valid: all_ok<=all_ok&guess_valid, match_count<=match_count+guess_valid.
REQ-019 SHALL support back-to-back acceptance: evaluation of byte k and acceptance of byte k+1 on the same edge.
REQ-020 SHALL hold byte_num/byte_guess stable between acceptances.
REQ-021 SHALL never evaluate a cycle where pend=0, so gaps in in_valid have no effect on the result.
REQ-022 SHALL move CHECK->DONE on the edge that evaluates byte index FLAG_LEN-1; done<=1, pass<=all_ok&guess_valid.
REQ-023 SHALL NOT terminate early on a mismatch; every attempt consumes exactly FLAG_LEN bytes, so completion timing is independent of content.
REQ-024 SHALL remain in DONE with in_ready=0, holding done, pass and match_count, until clear.
REQ-025 SHALL, on clear=1 in any state, go to IDLE, with idx=0, pend=0, all_ok=1, match_count=0, done=0, pass=0; byte_num/byte_guess are unchanged.
REQ-026 SHALL give clear priority over a simultaneous in_valid; that byte is not accepted.
REQ-027 SHALL saturate idx at FLAG_LEN; no wrap to 0 within an attempt.
REQ-028 SHALL have match_count wide enough for FLAG_LEN=32 (6 bits), never wrapping.

Reset
REQ-029 SHALL, on rst=1, immediately force state=IDLE, idx=0, pend=0, all_ok=1, byte_num=0, byte_guess=0, match_count=0, done=0, pass=0, in_ready=0 while rst is held.
REQ-030 SHALL, when rst asserts mid-attempt, discard partial progress; after release, the next accepted byte is index 0.
REQ-031 SHALL assert in_ready=1 on the first clock edge after rst deasserts.

Verification
REQ-032 SHALL cover: 32 correct flag bytes back-to-back -> done=1 one cycle after last acceptance, pass=1, match_count=32.
REQ-033 SHALL cover: correct bytes except index 5 wrong -> done on same cycle as REQ-032 case, pass=0, match_count=31.
REQ-034 SHALL cover: correct bytes with random in_valid gaps -> pass=1, match_count=32, byte_num sequence 0..31 with no repeats.
REQ-035 SHALL cover: clear asserted with in_valid=1 after 10 bytes -> byte not accepted; next acceptance has byte_num=0; match_count=0.
REQ-036 SHALL cover: rst pulse mid-cycle after 20 bytes -> outputs zero immediately; a fresh 32-byte correct attempt gives pass=1.
REQ-037 SHALL cover: in_valid held high in DONE for 10 cycles -> in_ready=0, done, pass and match_count unchanged.

Source files
------------

// File: rtl/guess_sequencer.sv
// Feeds one guess attempt byte-by-byte to an external combinational byte checker
// and collects the per-byte verdicts into a match count and a pass flag.
`default_nettype none

module guess_sequencer #(
  parameter int FLAG_LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [4:0] byte_num,
  output logic [7:0] byte_guess,
  input  logic       guess_valid,
  output logic [5:0] match_count,
  output logic       done,
  output logic       pass
);

  localparam logic [5:0] LEN  = 6'(FLAG_LEN);
  localparam logic [4:0] LAST = 5'(FLAG_LEN - 1);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t     state;
  logic [5:0] idx;
  logic       pend;
  logic       all_ok;
  logic       ready_q;
  logic       accept;
  logic [5:0] idx_nxt;

  // clear masks readiness combinationally so a colliding byte is never taken
  assign in_ready = ready_q & ~clear;
  assign accept   = in_valid & in_ready;
  assign idx_nxt  = accept ? idx + 6'd1 : idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 6'd0;
      pend        <= 1'b0;
      all_ok      <= 1'b1;
      ready_q     <= 1'b0;
      byte_num    <= 5'd0;
      byte_guess  <= 8'd0;
      match_count <= 6'd0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      idx         <= 6'd0;
      pend        <= 1'b0;
      all_ok      <= 1'b1;
      ready_q     <= 1'b1;
      match_count <= 6'd0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      if (accept) begin
        byte_guess <= in_data;
        byte_num   <= idx[4:0];
        idx        <= idx_nxt;
      end
      pend    <= accept;
      ready_q <= (idx_nxt < LEN);
      case (state)
        IDLE: begin
          if (accept) state <= CHECK;
        end
        CHECK: begin
          // verdict belongs to the byte registered on the previous edge
          if (pend) begin
            all_ok      <= all_ok & guess_valid;
            match_count <= match_count + {5'd0, guess_valid};
            if (byte_num == LAST) begin
              state   <= DONE;
              done    <= 1'b1;
              pass    <= all_ok & guess_valid;
              ready_q <= 1'b0;
            end
          end
        end
        DONE: begin
          ready_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_guess_sequencer.sv
// Directed bench for guess_sequencer; the byte checker is modelled by a flag table.
`default_nettype none

module tb_guess_sequencer;

  localparam int FLAG_LEN = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic [4:0] byte_num;
  logic [7:0] byte_guess;
  logic       guess_valid;
  logic [5:0] match_count;
  logic       done;
  logic       pass;

  logic [7:0] flag [FLAG_LEN];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign guess_valid = (byte_guess == flag[byte_num]);

  guess_sequencer #(.FLAG_LEN(FLAG_LEN)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .byte_num(byte_num), .byte_guess(byte_guess), .guess_valid(guess_valid),
    .match_count(match_count), .done(done), .pass(pass)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input bit gaps);
    int g;
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (g) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      if (i > 0) check("gap_hold_num", 32'(byte_num), 32'(i - 1));
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    #1 check("ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("byte_num", 32'(byte_num), 32'(i));
    check("byte_guess", 32'(byte_guess), 32'(d));
  endtask

  task automatic attempt(input int bad, input bit gaps, input int nbytes);
    for (int i = 0; i < nbytes; i++)
      send(i, (i == bad) ? ~flag[i] : flag[i], gaps);
    @(negedge clk);
    in_valid = 1'b0;
    if (nbytes == FLAG_LEN) begin
      check("done_before_eval", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("done_after_eval", 32'(done), 32'd1);
      check("ready_in_done", 32'(in_ready), 32'd0);
    end
  endtask

  task automatic do_clear(input bit with_valid);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = with_valid;
    in_data  = flag[10];
    #1 check("ready_during_clear", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_match", 32'(match_count), 32'd0);
    check("clear_done", 32'(done), 32'd0);
    check("clear_pass", 32'(pass), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < FLAG_LEN; i++) flag[i] = 8'(i * 37 + 11);

    #3;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_match", 32'(match_count), 32'd0);
    check("rst_num", 32'(byte_num), 32'd0);
    check("rst_guess", 32'(byte_guess), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // all correct, back-to-back
    attempt(-1, 1'b0, FLAG_LEN);
    check("a1_pass", 32'(pass), 32'd1);
    check("a1_match", 32'(match_count), 32'd32);
    do_clear(1'b0);

    // index 5 wrong
    attempt(5, 1'b0, FLAG_LEN);
    check("a2_pass", 32'(pass), 32'd0);
    check("a2_match", 32'(match_count), 32'd31);
    do_clear(1'b0);

    // correct bytes with random gaps
    attempt(-1, 1'b1, FLAG_LEN);
    check("a3_pass", 32'(pass), 32'd1);
    check("a3_match", 32'(match_count), 32'd32);

    // in_valid held high while done
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = flag[0];
      #1 check("done_hold_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check("done_hold_done", 32'(done), 32'd1);
    end
    check("done_hold_pass", 32'(pass), 32'd1);
    check("done_hold_match", 32'(match_count), 32'd32);
    check("done_hold_num", 32'(byte_num), 32'd31);
    in_valid = 1'b0;
    do_clear(1'b0);

    // clear collides with a valid byte after 10 bytes
    attempt(-1, 1'b0, 10);
    do_clear(1'b1);
    check("clear_num_kept", 32'(byte_num), 32'd9);
    attempt(-1, 1'b0, FLAG_LEN);
    check("a4_pass", 32'(pass), 32'd1);
    check("a4_match", 32'(match_count), 32'd32);
    do_clear(1'b0);

    // asynchronous reset mid-cycle after 20 bytes
    attempt(-1, 1'b0, 20);
    #2 rst = 1'b1;
    #1;
    check("arst_num", 32'(byte_num), 32'd0);
    check("arst_guess", 32'(byte_guess), 32'd0);
    check("arst_match", 32'(match_count), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("arst_ready_after", 32'(in_ready), 32'd1);
    attempt(-1, 1'b0, FLAG_LEN);
    check("a5_pass", 32'(pass), 32'd1);
    check("a5_match", 32'(match_count), 32'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
